lcd_delay_timer: RTL and testbench

//   Parametrised one-shot delay timer for the LCD interface controller.

---
 rtl/lcd_timing_pkg.sv | 39 +++
 rtl/lcd_delay_rom.sv | 37 +++
 rtl/lcd_delay_timer.sv | 110 +++++++++++
 tb/tb_lcd_delay_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing helpers, state encoding and default delay constants for the LCD delay timer.
package lcd_timing_pkg;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] RUN_ENC  = 2'd1;
   localparam logic [1:0] FIN_ENC  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      RUN  = RUN_ENC,
      FIN  = FIN_ENC
   } state_t;

   localparam int unsigned DEF_CLK_HZ  = 3_125_000;
   localparam int unsigned DEF_DLY0_US = 40;
   localparam int unsigned DEF_DLY1_US = 100;
   localparam int unsigned DEF_DLY2_US = 1000;
   localparam int unsigned DEF_DLY3_US = 15000;

   // Truncating microsecond-to-cycle conversion; a zero-length delay still takes one cycle.
   function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                                input longint unsigned us);
      longint unsigned cyc;
      cyc = (clk_hz * us) / 64'd1_000_000;
      if (cyc == 64'd0) cyc = 64'd1;
      return 32'(cyc);
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_delay_rom.sv
// Combinational delay-index to cycle-count lookup; out-of-range indices clamp to the last delay.
module lcd_delay_rom
   import lcd_timing_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
   parameter int unsigned NUM_DLY = 4,
   parameter int unsigned DLY0_US = DEF_DLY0_US,
   parameter int unsigned DLY1_US = DEF_DLY1_US,
   parameter int unsigned DLY2_US = DEF_DLY2_US,
   parameter int unsigned DLY3_US = DEF_DLY3_US,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic [SEL_W-1:0] sel,
   output logic [CNT_W-1:0] cnt_c
);

   localparam int unsigned CNT0 = us_to_cycles(64'(CLK_HZ), 64'(DLY0_US));
   localparam int unsigned CNT1 = us_to_cycles(64'(CLK_HZ), 64'(DLY1_US));
   localparam int unsigned CNT2 = us_to_cycles(64'(CLK_HZ), 64'(DLY2_US));
   localparam int unsigned CNT3 = us_to_cycles(64'(CLK_HZ), 64'(DLY3_US));

   int unsigned idx;

   always_comb begin
      idx   = 32'(sel);
      cnt_c = CNT_W'(CNT0);
      if (idx >= NUM_DLY) idx = NUM_DLY - 32'd1;
      case (idx)
         32'd1:   cnt_c = CNT_W'(CNT1);
         32'd2:   cnt_c = CNT_W'(CNT2);
         32'd3:   cnt_c = CNT_W'(CNT3);
         default: cnt_c = CNT_W'(CNT0);
      endcase
   end

endmodule

// File: rtl/lcd_delay_timer.sv
// One-shot selectable delay timer for the LCD sequencer: start -> busy -> one-cycle done.
// Optional feature macro: LCD_TIMER_ABORT_EN adds an abort input that cancels a running delay.
module lcd_delay_timer
   import lcd_timing_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
   parameter int unsigned NUM_DLY = 4,
   parameter int unsigned DLY0_US = DEF_DLY0_US,
   parameter int unsigned DLY1_US = DEF_DLY1_US,
   parameter int unsigned DLY2_US = DEF_DLY2_US,
   parameter int unsigned DLY3_US = DEF_DLY3_US,
   localparam int unsigned SEL_W  = (NUM_DLY > 1) ? $clog2(NUM_DLY) : 1,
   localparam int unsigned CNT_W  = $clog2(max4(us_to_cycles(64'(CLK_HZ), 64'(DLY0_US)),
                                                us_to_cycles(64'(CLK_HZ), 64'(DLY1_US)),
                                                us_to_cycles(64'(CLK_HZ), 64'(DLY2_US)),
                                                us_to_cycles(64'(CLK_HZ), 64'(DLY3_US))) + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SEL_W-1:0] sel,
`ifdef LCD_TIMER_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic             start_err,
   output logic [CNT_W-1:0] remaining
);

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [CNT_W-1:0] term, term_n;
   logic [CNT_W-1:0] rom_cnt;
   logic [CNT_W-1:0] remaining_n;
   logic             busy_n, done_n, err_n;

   lcd_delay_rom #(
      .CLK_HZ  (CLK_HZ),
      .NUM_DLY (NUM_DLY),
      .DLY0_US (DLY0_US),
      .DLY1_US (DLY1_US),
      .DLY2_US (DLY2_US),
      .DLY3_US (DLY3_US),
      .SEL_W   (SEL_W),
      .CNT_W   (CNT_W)
   ) u_rom (
      .sel   (sel),
      .cnt_c (rom_cnt)
   );

   // Next state; outputs are registered from the next state so they line up with it.
   always_comb begin
      state_n = state;
      count_n = count;
      term_n  = term;
      err_n   = 1'b0;
      case (state)
         IDLE, FIN: begin
            state_n = IDLE;
            if (start) begin
               term_n  = rom_cnt - CNT_W'(1);
               count_n = '0;
               state_n = (rom_cnt == CNT_W'(1)) ? FIN : RUN;
            end
         end
         RUN: begin
            err_n = start;
            if (count == term - CNT_W'(1)) begin
               state_n = FIN;
               count_n = term;
            end else begin
               count_n = count + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef LCD_TIMER_ABORT_EN
      if (abort && (state != IDLE)) begin
         state_n = IDLE;
         count_n = '0;
         err_n   = 1'b0;
      end
`endif
      busy_n      = (state_n == RUN);
      done_n      = (state_n == FIN);
      remaining_n = busy_n ? (term_n - count_n) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         term      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
         remaining <= '0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         term      <= term_n;
         busy      <= busy_n;
         done      <= done_n;
         start_err <= err_n;
         remaining <= remaining_n;
      end
   end

endmodule

// File: tb/tb_lcd_delay_timer.sv
// Bench for lcd_delay_timer: a default-parameter instance plus a short-delay instance (1 MHz, 3 delays).
module tb_lcd_delay_timer;

   localparam int A_CNT_W = 16;
   localparam int B_CNT_W = 14;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               a_reset, a_start;
   logic [1:0]         a_sel;
   logic               a_busy, a_done, a_err;
   logic [A_CNT_W-1:0] a_remaining;
   logic               b_reset, b_start;
   logic [1:0]         b_sel;
   logic               b_busy, b_done, b_err;
   logic [B_CNT_W-1:0] b_remaining;
`ifdef LCD_TIMER_ABORT_EN
   logic a_abort = 1'b0;
   logic b_abort = 1'b0;
`endif

   lcd_delay_timer u_a (
      .clk       (clk),
      .reset     (a_reset),
      .start     (a_start),
      .sel       (a_sel),
`ifdef LCD_TIMER_ABORT_EN
      .abort     (a_abort),
`endif
      .busy      (a_busy),
      .done      (a_done),
      .start_err (a_err),
      .remaining (a_remaining)
   );

   lcd_delay_timer #(
      .CLK_HZ  (1_000_000),
      .NUM_DLY (3),
      .DLY0_US (1),
      .DLY1_US (4),
      .DLY2_US (3),
      .DLY3_US (15000)
   ) u_b (
      .clk       (clk),
      .reset     (b_reset),
      .start     (b_start),
      .sel       (b_sel),
`ifdef LCD_TIMER_ABORT_EN
      .abort     (b_abort),
`endif
      .busy      (b_busy),
      .done      (b_done),
      .start_err (b_err),
      .remaining (b_remaining)
   );

   typedef struct {
      logic       rst;
      logic       st;
      logic [1:0] sel;
      logic       busy;
      logic       done;
      logic       err;
      int         rem;
   } vec_t;

   int   n_vec = 0;
   int   n_mis = 0;
   vec_t vecs[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic int pack_a();
      return {a_busy, a_done, a_err} * 100000 + int'(a_remaining);
   endfunction

   function automatic int pack_exp(input logic bz, input logic dn, input logic er, input int rem);
      return {bz, dn, er} * 100000 + rem;
   endfunction

   task automatic launch(input logic [1:0] s);
      a_start = 1'b1;
      a_sel   = s;
      tick();
      a_start = 1'b0;
   endtask

   // Runs from cycle 1 of a delay until done or the budget expires.
   task automatic wait_done(input int limit, output int cyc, output bit gap);
      cyc = 1;
      gap = 1'b0;
      while (!a_done && cyc < limit) begin
         if (!a_busy) gap = 1'b1;
         tick();
         cyc++;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time budget expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc, errs, err_cyc, dones;
      bit  gap;
      vec_t v;

      vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
      vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 3};
      vecs[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2};
      vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1};
      vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 0};
      vecs[7]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 2};
      vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1};
      vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 0};
      vecs[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 0};
      vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
      vecs[12] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 2};
      vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
      vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};

      a_reset = 1'b1; a_start = 1'b0; a_sel = 2'd0;
      b_reset = 1'b1; b_start = 1'b0; b_sel = 2'd0;
      tick();
      tick();
      check("reset_a", pack_a(), pack_exp(1'b0, 1'b0, 1'b0, 0));
      check("reset_b", {b_busy, b_done, b_err} * 100000 + int'(b_remaining),
            pack_exp(1'b0, 1'b0, 1'b0, 0));
      a_reset = 1'b0;
      b_reset = 1'b0;

      // Short-delay instance: N=1, start while running, back-to-back, clamp, reset mid-run.
      for (int i = 0; i < 15; i++) begin
         v = vecs[i];
         b_reset = v.rst;
         b_start = v.st;
         b_sel   = v.sel;
         tick();
         check($sformatf("vec%0d", i),
               {b_busy, b_done, b_err} * 100000 + int'(b_remaining),
               pack_exp(v.busy, v.done, v.err, v.rem));
      end
      b_reset = 1'b0; b_start = 1'b0; b_sel = 2'd0;

      // 40 us: busy 124 cycles with remaining 124..1, done at cycle 125.
      tick();
      launch(2'd0);
      for (int c = 1; c <= 125; c++) begin
         check($sformatf("sel0_cyc%0d", c), pack_a(),
               pack_exp(c < 125, c == 125, 1'b0, 125 - c));
         if (c < 125) tick();
      end
      // Start in the done cycle: next delay runs with no idle gap.
      launch(2'd2);
      check("b2b_first", pack_a(), pack_exp(1'b1, 1'b0, 1'b0, 3124));
      wait_done(4000, cyc, gap);
      check("b2b_done_cycle", cyc, 3125);
      check("b2b_gap", int'(gap), 0);

      // 15 ms delay.
      tick();
      launch(2'd3);
      wait_done(50000, cyc, gap);
      check("sel3_done_cycle", cyc, 46875);
      check("sel3_busy_gap", int'(gap), 0);

      // Start while running is flagged and does not disturb timing.
      tick();
      launch(2'd1);
      cyc = 1; errs = 0; err_cyc = 0;
      while (!a_done && cyc < 400) begin
         a_start = (cyc == 50);
         tick();
         cyc++;
         if (a_err) begin
            errs++;
            err_cyc = cyc;
         end
      end
      a_start = 1'b0;
      check("busy_start_done_cycle", cyc, 312);
      check("busy_start_err_count", errs, 1);
      check("busy_start_err_cycle", err_cyc, 51);

      // Reset in the middle of a delay drops the pending done.
      tick();
      launch(2'd2);
      for (int c = 1; c < 60; c++) tick();
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      check("rst_mid_run", pack_a(), pack_exp(1'b0, 1'b0, 1'b0, 0));
      dones = 0;
      for (int c = 0; c < 3200; c++) begin
         tick();
         if (a_done || a_busy) dones++;
      end
      check("rst_mid_run_no_done", dones, 0);

`ifdef LCD_TIMER_ABORT_EN
      // Abort mid-run: idle next cycle, no done.
      launch(2'd0);
      for (int c = 1; c < 10; c++) tick();
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      check("abort_run", pack_a(), pack_exp(1'b0, 1'b0, 1'b0, 0));
      dones = 0;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (a_done) dones++;
      end
      check("abort_no_done", dones, 0);

      // Abort together with start in the done cycle wins.
      launch(2'd0);
      wait_done(200, cyc, gap);
      check("abort_start_setup", cyc, 125);
      a_abort = 1'b1;
      a_start = 1'b1;
      tick();
      a_abort = 1'b0;
      a_start = 1'b0;
      check("abort_with_start", pack_a(), pack_exp(1'b0, 1'b0, 1'b0, 0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
